// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and load/store paths.
// One transaction in flight at a time; load/store has priority, with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            m_req,
  input  logic            m_we,
  input  logic [AW-1:0]   m_addr,
  input  logic [DW-1:0]   m_wdata,
  input  logic [DW/8-1:0] m_be,
  output logic [DW-1:0]   m_rdata,
  output logic            m_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_if,
  output logic            stall_mem
);

  localparam int BW = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

  stateT          state;
  stateT          nextState;
  logic           ownerM;
  logic [3:0]     starveCnt;
  logic           pickM;
  logic           pickIf;
  logic [AW-1:0]  reqAddr;
  logic           reqWe;
  logic [DW-1:0]  reqWdata;
  logic [BW-1:0]  reqBe;
  logic [DW-1:0]  ifRdataQ;
  logic [DW-1:0]  mRdataQ;

  function automatic logic [3:0] satInc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Load/store wins unless fetch has already lost STARVE_MAX times in a row.
  always_comb begin
    pickM  = 1'b0;
    pickIf = 1'b0;
    if (m_req && (starveCnt < STARVE_LIM)) pickM = 1'b1;
    else if (if_req)                       pickIf = 1'b1;
    else if (m_req)                        pickM = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (pickM || pickIf) nextState = REQ;
      REQ:     if (mem_gnt)         nextState = WAIT;
      WAIT:    if (mem_rvalid)      nextState = DONE;
      DONE:                         nextState = IDLE;
      default:                      nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ownerM    <= 1'b0;
      starveCnt <= 4'd0;
    end else if (state == IDLE) begin
      if (pickM) begin
        ownerM <= 1'b1;
        if (if_req) starveCnt <= satInc(starveCnt);
      end else if (pickIf) begin
        ownerM    <= 1'b0;
        starveCnt <= 4'd0;
      end
    end
  end

  // Request fields are only visible on the memory port while in REQ, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (pickM) begin
        reqAddr  <= m_addr;
        reqWe    <= m_we;
        reqWdata <= m_wdata;
        reqBe    <= m_we ? m_be : '1;
      end else if (pickIf) begin
        reqAddr  <= if_addr;
        reqWe    <= 1'b0;
        reqWdata <= '0;
        reqBe    <= '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifRdataQ <= '0;
      mRdataQ  <= '0;
    end else if ((state == WAIT) && mem_rvalid && !reqWe) begin
      if (ownerM) mRdataQ  <= mem_rdata;
      else        ifRdataQ <= mem_rdata;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (state == REQ) begin
      mem_req   = 1'b1;
      mem_we    = reqWe;
      mem_addr  = reqAddr;
      mem_wdata = reqWdata;
      mem_be    = reqBe;
    end
    if_ready  = (state == DONE) && !ownerM;
    m_ready   = (state == DONE) && ownerM;
    if_rdata  = ifRdataQ;
    m_rdata   = mRdataQ;
    stall_if  = if_req & ~if_ready;
    stall_mem = m_req & ~m_ready;
  end

endmodule
